// File: rtl/counter_dn_32bit_uf.sv
// Loadable down-counter/timer with a one-cycle underflow pulse and optional auto-reload.
// Optional sticky underflow flag (uf_clr / uf_sticky) is built when COUNTER_DN_STICKY_EN is defined.
module counter_dn_32bit_uf #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             stop,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] count,
   output logic             underflow,
   output logic             busy,
   output logic [1:0]       state_dbg
`ifdef COUNTER_DN_STICKY_EN
   ,
   input  logic             uf_clr,
   output logic             uf_sticky
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] reload;
   logic [WIDTH-1:0] reload_nxt;
   logic [WIDTH-1:0] count_nxt;
   logic             uf_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         count     <= '0;
         reload    <= '0;
         underflow <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         count     <= count_nxt;
         reload    <= reload_nxt;
         underflow <= uf_nxt;
         busy      <= (state_nxt == S_RUN);
      end
   end

   // Command priority is load > stop > start; expiry is only evaluated when no command wins.
   always_comb begin
      state_nxt  = state;
      count_nxt  = count;
      reload_nxt = reload;
      uf_nxt     = 1'b0;
      if (load) begin
         count_nxt  = load_val;
         reload_nxt = load_val;
         state_nxt  = S_IDLE;
      end else if (stop && (state == S_RUN)) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) state_nxt = S_RUN;
            end
            S_DONE: begin
               if (start) begin
                  count_nxt = reload;
                  state_nxt = S_RUN;
               end
            end
            S_RUN: begin
               if (count != '0) begin
                  count_nxt = count - WIDTH'(1);
               end else begin
                  uf_nxt = 1'b1;
                  if (auto_reload) count_nxt = reload;
                  else             state_nxt = S_DONE;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   assign state_dbg = state;

`ifdef COUNTER_DN_STICKY_EN
   // Set tracks the same edge that raises underflow, so a same-edge clear loses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      uf_sticky <= 1'b0;
      else if (uf_nxt) uf_sticky <= 1'b1;
      else if (uf_clr) uf_sticky <= 1'b0;
   end
`endif

endmodule
